// File: rtl/fir_sample_loader.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | fir_sample_loader : drains the sample FIFO into IMEM, then sweeps CONV    |
// | Revision 1.0 - initial release                                            |
// +---------------------------------------------------------------------------+
module fir_sample_loader #(
   parameter int DATA_W      = 16,
   parameter int ADDR_W      = 6,
   parameter int NUM_SAMPLES = 64
) (
   input  logic              rclk,
   input  logic              rrst,
   input  logic              start,
   input  logic              abort,
   input  logic              rempty,
   input  logic [DATA_W-1:0] rdata,
   output logic              rinc,
   output logic              imem_wen,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [DATA_W-1:0] imem_wdata,
   output logic              conv_en,
   output logic [ADDR_W-1:0] conv_addr,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W:0]   load_cnt
);

   localparam logic [ADDR_W:0]   c_NUM       = (ADDR_W+1)'(NUM_SAMPLES);
   localparam logic [ADDR_W:0]   c_LAST_POP  = (ADDR_W+1)'(NUM_SAMPLES - 1);
   localparam logic [ADDR_W-1:0] c_LAST_ADDR = ADDR_W'(NUM_SAMPLES - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_DRAIN = 3'd2,
      S_CONV  = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t            r_state;
   state_t            w_next;
   logic              w_rinc;
   logic [ADDR_W:0]   r_pop_cnt;
   logic              r_wen;
   logic [ADDR_W-1:0] r_waddr;
   logic [DATA_W-1:0] r_wdata;
   logic              r_conv_en;
   logic [ADDR_W-1:0] r_conv_addr;
   logic              r_busy;
   logic              r_done;

   // Pop is gated by reset so a word is never pulled and then discarded.
   always_comb begin
      w_next = r_state;
      w_rinc = (r_state == S_LOAD) && !rempty && (r_pop_cnt < c_NUM) && !rrst;
      case (r_state)
         S_IDLE:  if (start) w_next = S_LOAD;
         S_LOAD:  if (w_rinc && (r_pop_cnt == c_LAST_POP)) w_next = S_DRAIN;
         S_DRAIN: w_next = S_CONV;
         S_CONV:  if (r_conv_addr == c_LAST_ADDR) w_next = S_DONE;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
      if (abort) w_next = S_IDLE;
   end

   always_ff @(posedge rclk) begin
      if (rrst) r_state <= S_IDLE;
      else      r_state <= w_next;
   end

   always_ff @(posedge rclk) begin
      if (rrst) begin
         r_pop_cnt   <= '0;
         r_wen       <= 1'b0;
         r_waddr     <= '0;
         r_wdata     <= '0;
         r_conv_en   <= 1'b0;
         r_conv_addr <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_wen <= w_rinc;
         if (w_rinc) begin
            r_waddr   <= r_pop_cnt[ADDR_W-1:0];
            r_wdata   <= rdata;
            r_pop_cnt <= r_pop_cnt + 1'b1;
         end
         if ((r_state == S_IDLE) && start && !abort) r_pop_cnt <= '0;
         r_conv_en   <= (w_next == S_CONV);
         r_conv_addr <= ((w_next == S_CONV) && (r_state == S_CONV)) ? r_conv_addr + 1'b1 : '0;
         r_busy      <= (w_next == S_LOAD) || (w_next == S_DRAIN) || (w_next == S_CONV);
         r_done      <= (w_next == S_DONE);
      end
   end

   // Every pop is written exactly once, so the pop count doubles as load_cnt.
   assign rinc       = w_rinc;
   assign imem_wen   = r_wen;
   assign imem_addr  = r_waddr;
   assign imem_wdata = r_wdata;
   assign conv_en    = r_conv_en;
   assign conv_addr  = r_conv_addr;
   assign busy       = r_busy;
   assign done       = r_done;
   assign load_cnt   = r_pop_cnt;

endmodule
`default_nettype wire
